dut_seq_compute: RTL and testbench
==================================

Name: dut_seq_compute

Overview:
- Parametrised, sequential successor to the combinational sample device-under-test.
- Splits `dut_input` into halves A (upper) and B (lower) and computes one of four operations.
- Multiply uses a multi-cycle shift-add engine. The other operations complete in one compute cycle.
- Results are held in a register with a start/busy/done handshake. A single selected result bit is exposed for the probe/capture logic.

Parameters:
- HALF_WIDTH, 16, width of each operand; `dut_input` is 2*HALF_WIDTH bits.
- SELECT_WIDTH, 32, width of `dut_signal_select`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dut_input  input  2*HALF_WIDTH  operands; A = upper half, B = lower half.
- dut_mode  input  2  operation select: 0 = A*B, 1 = A+B, 2 = A^B, 3 = A-B.
- dut_start  input  1  request a computation; sampled on a rising edge.
- dut_signal_select  input  SELECT_WIDTH  index of the result bit driven on `dut_output`.
- dut_busy  output  1  high while a computation is in progress.
- dut_done  output  1  one-cycle pulse when `dut_result` has been updated.
- dut_result  output  2*HALF_WIDTH  registered result of the last completed computation.
- dut_output  output  1  `dut_result[dut_signal_select]`.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - `dut_busy` = 0, `dut_done` = 0, `dut_result` = 0
  - internal operand, accumulator and counter registers = 0
- Reset mid-operation: aborts the computation; `dut_done` is not asserted and `dut_result` reads 0.
- State machine:
  - IDLE: `dut_busy` = 0, `dut_done` = 0.
    - On an edge with `dut_start` = 1: latch A, B and `dut_mode`; clear the accumulator; load the iteration counter; go to RUN.
  - RUN: `dut_busy` = 1.
    - Multiply: HALF_WIDTH iterations, one per cycle. Each iteration adds (A << i) to the accumulator if B[i] = 1. The bit order is free as long as the final value is exact.
    - Other modes: a single RUN cycle computes the result.
    - On the final RUN cycle: write the result into `dut_result` and go to DONE.
  - DONE: `dut_busy` = 0, `dut_done` = 1 for exactly this one cycle.
    - If `dut_start` = 1 on the edge leaving DONE, start a new computation directly (back-to-back). Otherwise go to IDLE.
- Latency: call the edge that samples start E0. `dut_done` is high in the cycle following edge E0+N, where N = HALF_WIDTH for multiply and N = 1 otherwise.
- Handshake rules:
  - `dut_start` is ignored while in RUN; no queueing.
  - Operands and mode are captured only at acceptance. Changes to `dut_input` or `dut_mode` during RUN have no effect.
- Arithmetic and width rules, all results 2*HALF_WIDTH bits:
  - Multiply: exact unsigned product.
  - Add: zero-extended unsigned sum, so the carry lands in bit HALF_WIDTH.
  - XOR: zero-extended.
  - Subtract: (A - B) modulo 2^(2*HALF_WIDTH), i.e. two's complement wrap across the full width.
- `dut_result` holds its value until the next completion or reset.
- `dut_output` is combinational from `dut_result` and `dut_signal_select`:
  - select < 2*HALF_WIDTH: the indexed result bit.
  - select >= 2*HALF_WIDTH: 0, with no X and no wrap.
- HALF_WIDTH = 1 must work: multiply takes 1 RUN cycle.

Test Plan:
- Multiply, defaults: `dut_input` = 0x0003_0005, mode 0, pulse start → `dut_busy` high for 16 cycles; `dut_done` pulses at E0+17; `dut_result` = 0x0000000F. Then select = 3 → `dut_output` = 1; select = 4 → `dut_output` = 0.
- Multiply extremes: 0xFFFF_FFFF, mode 0 → `dut_result` = 0xFFFE0001. Separately, 0x0000_1234 → `dut_result` = 0.
- Short modes, each with done at E0+2:
  - add 0xFFFF_0001 → 0x00010000
  - xor 0x00FF_0F0F → 0x00000FF0
  - sub 0x0001_0002 → 0xFFFFFFFF
- Start during RUN: start multiply, re-pulse start at E0+5 with a new input → ignored; only one done pulse, carrying the first product. Next, hold start high through DONE → back-to-back operation accepted with no IDLE cycle.
- Out-of-range select: `dut_result` = 0xFFFFFFFF with select = 32 and select = 0xFFFFFFFF → `dut_output` = 0; select = 31 → 1.
- Reset mid-operation: assert reset at E0+8 of a multiply → next cycle busy = 0, done = 0, result = 0; no done pulse follows. A fresh start afterwards yields the correct result.

Source files
------------

// File: rtl/dut_seq_compute.sv
// Sequential compute unit: splits dut_input into halves A/B and computes A*B, A+B, A^B or A-B
// behind a start/busy/done handshake. Multiply runs as a HALF_WIDTH-cycle shift-add loop.
module dut_seq_compute #(
   parameter int unsigned HALF_WIDTH   = 16,
   parameter int unsigned SELECT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2*HALF_WIDTH-1:0]   dut_input,
   input  logic [1:0]                dut_mode,
   input  logic                      dut_start,
   input  logic [SELECT_WIDTH-1:0]   dut_signal_select,
   output logic                      dut_busy,
   output logic                      dut_done,
   output logic [2*HALF_WIDTH-1:0]   dut_result,
   output logic                      dut_output
);

   localparam int unsigned W     = 2 * HALF_WIDTH;
   localparam int unsigned CNT_W = (HALF_WIDTH > 1) ? $clog2(HALF_WIDTH) : 1;
   localparam int unsigned IDX_W = $clog2(W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] MODE_MUL = 2'd0;
   localparam logic [1:0] MODE_ADD = 2'd1;
   localparam logic [1:0] MODE_XOR = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nx;
   logic                  accept_c;
   logic                  last_c;
   logic [W-1:0]          a_sh;
   logic [HALF_WIDTH-1:0] b_sh;
   logic [1:0]            mode_q;
   logic [W-1:0]          acc;
   logic [CNT_W-1:0]      cnt;
   logic [W-1:0]          mul_sum_c;
   logic [W-1:0]          res_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and handshake decode
   always_comb begin
      state_nx = state;
      accept_c = 1'b0;
      last_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (dut_start) begin
               accept_c = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == '0) begin
               last_c   = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            if (dut_start) begin
               accept_c = 1'b1;
               state_nx = S_RUN;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // a_sh still holds the unshifted, zero-extended A during the single RUN cycle of short modes
   always_comb begin
      mul_sum_c = acc + (b_sh[0] ? a_sh : '0);
      res_c     = '0;
      case (mode_q)
         MODE_MUL: res_c = mul_sum_c;
         MODE_ADD: res_c = a_sh + W'(b_sh);
         MODE_XOR: res_c = a_sh ^ W'(b_sh);
         default:  res_c = a_sh - W'(b_sh);
      endcase
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         dut_busy   <= 1'b0;
         dut_done   <= 1'b0;
         dut_result <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         mode_q     <= '0;
         acc        <= '0;
         cnt        <= '0;
      end else begin
         dut_busy <= (state_nx == S_RUN);
         dut_done <= (state_nx == S_DONE);
         if (accept_c) begin
            a_sh   <= W'(dut_input[W-1:HALF_WIDTH]);
            b_sh   <= dut_input[HALF_WIDTH-1:0];
            mode_q <= dut_mode;
            acc    <= '0;
            cnt    <= (dut_mode == MODE_MUL) ? CNT_W'(HALF_WIDTH - 1) : '0;
         end else if (state == S_RUN) begin
            acc  <= mul_sum_c;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            if (last_c) dut_result <= res_c;
            else        cnt        <= cnt - CNT_W'(1);
         end
      end
   end

   // Out-of-range selects read as 0 rather than wrapping onto a low bit
   assign dut_output = (dut_signal_select < SELECT_WIDTH'(W)) ?
                       dut_result[dut_signal_select[IDX_W-1:0]] : 1'b0;

endmodule

// File: tb/tb_dut_seq_compute.sv
// Self-checking bench for dut_seq_compute: directed vector table, handshake corner sequences
// and randomized operations compared against an arithmetic reference model.
module tb_dut_seq_compute;

   localparam int unsigned HW = 16;
   localparam int unsigned W  = 2 * HW;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  dut_input;
   logic [1:0]    dut_mode;
   logic          dut_start;
   logic [31:0]   dut_signal_select;
   logic          dut_busy;
   logic          dut_done;
   logic [W-1:0]  dut_result;
   logic          dut_output;

   always #5 clk = ~clk;

   dut_seq_compute #(.HALF_WIDTH(HW), .SELECT_WIDTH(32)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .dut_input         (dut_input),
      .dut_mode          (dut_mode),
      .dut_start         (dut_start),
      .dut_signal_select (dut_signal_select),
      .dut_busy          (dut_busy),
      .dut_done          (dut_done),
      .dut_result        (dut_result),
      .dut_output        (dut_output)
   );

   typedef struct {
      logic [31:0] din;
      logic [1:0]  mode;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_op(input logic [31:0] din, input logic [1:0] mode);
      logic [63:0] a;
      logic [63:0] b;
      a = 64'(din[31:16]);
      b = 64'(din[15:0]);
      case (mode)
         2'd0:    ref_op = 32'(a * b);
         2'd1:    ref_op = 32'(a + b);
         2'd2:    ref_op = 32'(a ^ b);
         default: ref_op = 32'(a - b);
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] mode);
      ref_lat = (mode == 2'd0) ? int'(HW) : 1;
   endfunction

   // Launch one operation from IDLE; lat = k where done is seen after edge E0+k (-1 on timeout)
   task automatic run_op(input logic [31:0] din, input logic [1:0] mode,
                         output logic [31:0] res, output int lat, output int busy_cycles);
      dut_input = din;
      dut_mode  = mode;
      dut_start = 1'b1;
      tick();
      dut_start   = 1'b0;
      lat         = -1;
      busy_cycles = 0;
      for (int k = 1; k <= 40; k++) begin
         if (dut_busy) busy_cycles++;
         tick();
         if (dut_done) begin
            lat = k;
            break;
         end
      end
      res = dut_result;
      check("busy_low_at_done", 32'(dut_busy), 32'd0);
      tick();
      check("done_one_cycle", 32'(dut_done), 32'd0);
   endtask

   logic [31:0] res;
   logic [31:0] got;
   logic [31:0] exp_v;
   int          lat;
   int          bc;
   int          dones;
   logic [1:0]  m;
   logic [31:0] din;
   int          sel;

   initial begin
      vecs[0] = '{32'h0003_0005, 2'd0, 32'h0000_000F, 16};
      vecs[1] = '{32'hFFFF_FFFF, 2'd0, 32'hFFFE_0001, 16};
      vecs[2] = '{32'h0000_1234, 2'd0, 32'h0000_0000, 16};
      vecs[3] = '{32'hFFFF_0001, 2'd1, 32'h0001_0000, 1};
      vecs[4] = '{32'h00FF_0F0F, 2'd2, 32'h0000_0FF0, 1};
      vecs[5] = '{32'h0001_0002, 2'd3, 32'hFFFF_FFFF, 1};

      reset             = 1'b1;
      dut_input         = '0;
      dut_mode          = '0;
      dut_start         = 1'b0;
      dut_signal_select = '0;
      tick(); tick(); tick();
      check("reset_busy",   32'(dut_busy),   32'd0);
      check("reset_done",   32'(dut_done),   32'd0);
      check("reset_result", dut_result,      32'd0);
      check("reset_output", 32'(dut_output), 32'd0);
      reset = 1'b0;
      tick();

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].din, vecs[i].mode, res, lat, bc);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_lat));
      end

      // Bit probe on a small product
      run_op(32'h0003_0005, 2'd0, res, lat, bc);
      dut_signal_select = 32'd3; #1;
      check("sel3_output", 32'(dut_output), 32'd1);
      dut_signal_select = 32'd4; #1;
      check("sel4_output", 32'(dut_output), 32'd0);

      // Out-of-range selects on an all-ones result
      run_op(32'h0001_0002, 2'd3, res, lat, bc);
      dut_signal_select = 32'd32; #1;
      check("sel32_output", 32'(dut_output), 32'd0);
      dut_signal_select = 32'hFFFF_FFFF; #1;
      check("selmax_output", 32'(dut_output), 32'd0);
      dut_signal_select = 32'd31; #1;
      check("sel31_output", 32'(dut_output), 32'd1);

      // Start re-pulsed during RUN with new operands must be ignored
      dut_input = 32'h0007_0009;
      dut_mode  = 2'd0;
      dut_start = 1'b1;
      tick();
      dones = 0;
      lat   = -1;
      got   = '0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            dut_input = 32'h00AB_00CD;
            dut_mode  = 2'd1;
            dut_start = 1'b1;
         end else begin
            dut_start = 1'b0;
         end
         tick();
         if (dut_done) begin
            dones++;
            if (lat < 0) lat = k;
            got = dut_result;
         end
      end
      check("ignore_start_dones",   32'(dones), 32'd1);
      check("ignore_start_latency", 32'(lat),   32'd16);
      check("ignore_start_result",  got,        32'd63);

      // Back-to-back: start held through DONE, operands changed during RUN
      dut_input = 32'h1234_0001;
      dut_mode  = 2'd1;
      dut_start = 1'b1;
      tick();
      check("b2b_busy_first", 32'(dut_busy), 32'd1);
      dut_input = 32'h00FF_0F0F;
      dut_mode  = 2'd2;
      tick();
      check("b2b_done_first",   32'(dut_done), 32'd1);
      check("b2b_result_first", dut_result,    32'h0000_1235);
      tick();
      check("b2b_busy_second", 32'(dut_busy), 32'd1);
      check("b2b_no_idle",     32'(dut_done), 32'd0);
      dut_start = 1'b0;
      tick();
      check("b2b_done_second",   32'(dut_done), 32'd1);
      check("b2b_result_second", dut_result,    32'h0000_0FF0);
      tick();
      check("b2b_idle_after", 32'({dut_busy, dut_done}), 32'd0);

      // Reset sampled at E0+8 of a multiply
      dut_input = 32'h0003_0005;
      dut_mode  = 2'd0;
      dut_start = 1'b1;
      tick();
      dut_start = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      reset = 1'b1;
      tick();
      check("midreset_busy",   32'(dut_busy), 32'd0);
      check("midreset_done",   32'(dut_done), 32'd0);
      check("midreset_result", dut_result,    32'd0);
      reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (dut_done) dones++;
      end
      check("midreset_no_done", 32'(dones), 32'd0);
      run_op(32'h0102_0304, 2'd0, res, lat, bc);
      check("post_reset_result",  res,       ref_op(32'h0102_0304, 2'd0));
      check("post_reset_latency", 32'(lat),  32'd16);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         din = $urandom;
         m   = 2'($urandom_range(0, 3));
         run_op(din, m, res, lat, bc);
         exp_v = ref_op(din, m);
         check($sformatf("rand%0d_result din=%08h mode=%0d", i, din, m), res, exp_v);
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(m)));
         sel = int'($urandom_range(0, 40));
         dut_signal_select = 32'(sel); #1;
         check($sformatf("rand%0d_sel%0d", i, sel), 32'(dut_output),
               32'((sel < 32) ? exp_v[sel] : 1'b0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
